// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants (640x480 @ 60 Hz defaults) and small helpers
// used by the timing generator and downstream graphics blocks.
package vga_timing_pkg;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned FRAME_W = 8;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic display_on;
    } video_ctl_t;

    function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

    function automatic logic sync_level(input logic active, input logic active_high);
        return active_high ? active : ~active;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N up counter with enable; exposes the next value and a wrap flag so
// the parent can register outputs that line up with the counter.
module wrap_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned MODULUS = H_TOTAL,
    parameter int unsigned W       = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    // Next count; >= keeps any out-of-range value from persisting
    always_comb begin
        wrap       = 1'b0;
        count_next = count;
        if (en) begin
            if (count >= LAST) begin
                wrap       = 1'b1;
                count_next = '0;
            end else begin
                count_next = count + W'(1);
            end
        end else begin
            count_next = count;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal/vertical counters with registered
// sync, blanking and line/frame strobes aligned to hpos/vpos.
module video_timing_gen #(
    parameter int unsigned H_DISPLAY        = vga_timing_pkg::H_DISPLAY,
    parameter int unsigned H_FRONT          = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC           = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK           = vga_timing_pkg::H_BACK,
    parameter int unsigned V_DISPLAY        = vga_timing_pkg::V_DISPLAY,
    parameter int unsigned V_FRONT          = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC           = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK           = vga_timing_pkg::V_BACK,
    parameter bit          SYNC_ACTIVE_HIGH = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 pix_en,
    output logic [vga_timing_pkg::CNT_W-1:0]     hpos,
    output logic [vga_timing_pkg::CNT_W-1:0]     vpos,
    output logic                                 hsync,
    output logic                                 vsync,
    output logic                                 display_on,
    output logic                                 line_start,
    output logic                                 frame_start,
    output logic [vga_timing_pkg::FRAME_W-1:0]   frame_count
);

    import vga_timing_pkg::*;

    localparam int unsigned H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);

    logic [CNT_W-1:0] h_next_s;
    logic [CNT_W-1:0] v_next_s;
    logic             h_wrap_s;
    logic             v_wrap_s;
    logic             v_en_s;
    video_ctl_t       ctl_next_s;

    assign v_en_s = pix_en & h_wrap_s;

    wrap_counter #(.MODULUS(H_TOT), .W(CNT_W)) u_hcnt (
        .clk        (clk),
        .reset      (reset),
        .en         (pix_en),
        .count      (hpos),
        .count_next (h_next_s),
        .wrap       (h_wrap_s)
    );

    wrap_counter #(.MODULUS(V_TOT), .W(CNT_W)) u_vcnt (
        .clk        (clk),
        .reset      (reset),
        .en         (v_en_s),
        .count      (vpos),
        .count_next (v_next_s),
        .wrap       (v_wrap_s)
    );

    // Decode sync/visible state for the position the counters move to
    always_comb begin
        ctl_next_s.hsync      = sync_level(in_window(h_next_s, HS_START, HS_END), SYNC_ACTIVE_HIGH);
        ctl_next_s.vsync      = sync_level(in_window(v_next_s, VS_START, VS_END), SYNC_ACTIVE_HIGH);
        ctl_next_s.display_on = (h_next_s < H_VIS) && (v_next_s < V_VIS);
    end

    // Output registers; reset forces syncs inactive so no pulse is stretched
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync       <= sync_level(1'b0, SYNC_ACTIVE_HIGH);
            vsync       <= sync_level(1'b0, SYNC_ACTIVE_HIGH);
            display_on  <= 1'b1;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
            frame_count <= '0;
        end else if (pix_en) begin
            hsync       <= ctl_next_s.hsync;
            vsync       <= ctl_next_s.vsync;
            display_on  <= ctl_next_s.display_on;
            line_start  <= h_wrap_s;
            frame_start <= v_wrap_s;
            if (v_wrap_s) begin
                frame_count <= frame_count + FRAME_W'(1);
            end else begin
                frame_count <= frame_count;
            end
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default-timing instance and a shrunken,
// active-high instance, both checked every cycle against an arithmetic model.
module tb_video_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic pix_en;

    logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos;
    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [7:0] d_fc, s_fc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    video_timing_gen dut_def (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hpos(d_hpos), .vpos(d_vpos), .hsync(d_hs), .vsync(d_vs),
        .display_on(d_de), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
    );

    video_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_ACTIVE_HIGH(1'b1)
    ) dut_sm (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hs), .vsync(s_vs),
        .display_on(s_de), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    // Model state: pixels advanced since the last reset, and whether the
    // last edge was a reset or an advance (strobes only follow those).
    int unsigned t_adv = 0;
    bit          last_adv = 1'b0;
    bit          model_valid = 1'b0;

    function automatic exp_t model(input int unsigned t,
                                   input int unsigned hd, input int unsigned hf,
                                   input int unsigned hsw, input int unsigned hb,
                                   input int unsigned vd, input int unsigned vf,
                                   input int unsigned vsw, input int unsigned vb,
                                   input bit sah, input bit adv);
        exp_t e;
        int unsigned ht, vt, h, v;
        bit hact, vact;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        h = t % ht;
        v = (t / ht) % vt;
        hact = (h >= hd + hf) && (h < hd + hf + hsw);
        vact = (v >= vd + vf) && (v < vd + vf + vsw);
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.hs = sah ? hact : !hact;
        e.vs = sah ? vact : !vact;
        e.de = (h < hd) && (v < vd);
        e.ls = adv && (h == 0);
        e.fs = adv && (h == 0) && (v == 0);
        e.fc = 8'((t / (ht * vt)) % 256);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            t_adv       <= 0;
            last_adv    <= 1'b1;
            model_valid <= 1'b1;
        end else if (pix_en) begin
            t_adv    <= t_adv + 1;
            last_adv <= 1'b1;
        end else begin
            last_adv <= 1'b0;
        end
    end

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        exp_t e;
        if (model_valid) begin
            e = model(t_adv, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, last_adv);
            chk("def_hpos", 32'(d_hpos), 32'(e.h));
            chk("def_vpos", 32'(d_vpos), 32'(e.v));
            chk("def_hsync", 32'(d_hs), 32'(e.hs));
            chk("def_vsync", 32'(d_vs), 32'(e.vs));
            chk("def_display_on", 32'(d_de), 32'(e.de));
            chk("def_line_start", 32'(d_ls), 32'(e.ls));
            chk("def_frame_start", 32'(d_fs), 32'(e.fs));
            chk("def_frame_count", 32'(d_fc), 32'(e.fc));
            e = model(t_adv, 8, 2, 3, 3, 5, 1, 2, 2, 1'b1, last_adv);
            chk("sm_hpos", 32'(s_hpos), 32'(e.h));
            chk("sm_vpos", 32'(s_vpos), 32'(e.v));
            chk("sm_hsync", 32'(s_hs), 32'(e.hs));
            chk("sm_vsync", 32'(s_vs), 32'(e.vs));
            chk("sm_display_on", 32'(s_de), 32'(e.de));
            chk("sm_line_start", 32'(s_ls), 32'(e.ls));
            chk("sm_frame_start", 32'(s_fs), 32'(e.fs));
            chk("sm_frame_count", 32'(s_fc), 32'(e.fc));
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low, first_h, first_v, de_cnt, ls_cnt, fs_cnt, lines, fc255;
        bit found;
        bit pats [4];
        pats[0] = 1'b1; pats[1] = 1'b0; pats[2] = 1'b0; pats[3] = 1'b1;

        // Reset with pix_en high, then release
        reset  = 1'b1;
        pix_en = 1'b1;
        @(negedge clk); #2;
        chk("rst_def_hpos", 32'(d_hpos), 32'd0);
        chk("rst_def_vpos", 32'(d_vpos), 32'd0);
        chk("rst_def_line_start", 32'(d_ls), 32'd1);
        chk("rst_def_frame_start", 32'(d_fs), 32'd1);
        chk("rst_def_hsync", 32'(d_hs), 32'd1);
        chk("rst_def_display_on", 32'(d_de), 32'd1);
        chk("rst_sm_hsync", 32'(s_hs), 32'd0);
        chk("rst_def_frame_count", 32'(d_fc), 32'd0);
        reset = 1'b0;
        repeat (799) @(negedge clk);
        #2;
        chk("run799_def_hpos", 32'(d_hpos), 32'd799);
        chk("run799_def_vpos", 32'(d_vpos), 32'd0);
        chk("run799_sm_hpos", 32'(s_hpos), 32'd15);
        chk("run799_sm_vpos", 32'(s_vpos), 32'd9);
        chk("run799_sm_frame_count", 32'(s_fc), 32'd4);

        // One full visible line on the default instance (line 1)
        low = 0; first_h = -1; de_cnt = 0; ls_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk); #2;
            if (d_hs == 1'b0) begin
                if (first_h < 0) first_h = int'(d_hpos);
                low++;
            end
            if (d_de) de_cnt++;
            if (d_ls) ls_cnt++;
        end
        chk("line_hsync_low_cycles", 32'(low), 32'd96);
        chk("line_hsync_first_hpos", 32'(first_h), 32'd656);
        chk("line_display_on_cycles", 32'(de_cnt), 32'd640);
        chk("line_line_start_count", 32'(ls_cnt), 32'd1);

        // pix_en pattern 1,0,0,1 from hpos 799
        for (int k = 0; k < 4; k++) begin
            pix_en = pats[k];
            @(negedge clk); #2;
            if (!pats[k]) begin
                chk("hold_def_line_start", 32'(d_ls), 32'd0);
                chk("hold_def_frame_start", 32'(d_fs), 32'd0);
                chk("hold_sm_line_start", 32'(s_ls), 32'd0);
            end
        end
        chk("enable_def_hpos", 32'(d_hpos), 32'd1);
        chk("enable_def_vpos", 32'(d_vpos), 32'd2);
        pix_en = 1'b1;

        // Reset in the middle of an hsync pulse
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (d_hpos == 10'd700) begin
                found = 1'b1;
                break;
            end
            @(negedge clk); #2;
        end
        chk("midline_reach_700", 32'(found), 32'd1);
        chk("midline_hsync_active", 32'(d_hs), 32'd0);
        reset = 1'b1;
        @(negedge clk); #2;
        chk("midline_def_hpos", 32'(d_hpos), 32'd0);
        chk("midline_def_vpos", 32'(d_vpos), 32'd0);
        chk("midline_def_hsync", 32'(d_hs), 32'd1);
        chk("midline_def_frame_count", 32'(d_fc), 32'd0);
        chk("midline_sm_frame_count", 32'(s_fc), 32'd0);
        reset = 1'b0;

        // One full frame of the small instance, starting at (0,0)
        low = 0; first_h = -1; first_v = -1; lines = 0; ls_cnt = 0;
        for (int i = 0; i < 160; i++) begin
            if (s_vs) begin
                if (first_h < 0) begin
                    first_h = int'(s_hpos);
                    first_v = int'(s_vpos);
                end
                low++;
            end
            if (s_de && s_hpos == 10'd0) lines++;
            if (s_ls) ls_cnt++;
            @(negedge clk); #2;
        end
        chk("frame_vsync_cycles", 32'(low), 32'd32);
        chk("frame_vsync_first_h", 32'(first_h), 32'd0);
        chk("frame_vsync_first_v", 32'(first_v), 32'd6);
        chk("frame_visible_lines", 32'(lines), 32'd5);
        chk("frame_line_starts", 32'(ls_cnt), 32'd10);
        chk("frame_end_frame_count", 32'(s_fc), 32'd1);
        chk("frame_end_frame_start", 32'(s_fs), 32'd1);

        // 255 more frames: frame_count must wrap back to 0
        ls_cnt = 0; fs_cnt = 0; fc255 = -1;
        for (int i = 0; i < 255 * 160; i++) begin
            @(negedge clk); #2;
            if (s_ls) ls_cnt++;
            if (s_fs) fs_cnt++;
            if (i == 254 * 160 - 1) fc255 = int'(s_fc);
        end
        chk("wrap_frame_count_255", 32'(fc255), 32'd255);
        chk("wrap_frame_count_0", 32'(s_fc), 32'd0);
        chk("wrap_line_starts", 32'(ls_cnt), 32'd2550);
        chk("wrap_frame_starts", 32'(fs_cnt), 32'd255);

        // Mid-frame reset on the small instance at (7,4)
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (s_hpos == 10'd7 && s_vpos == 10'd4) begin
                found = 1'b1;
                break;
            end
            @(negedge clk); #2;
        end
        chk("midframe_reach", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clk); #2;
        chk("midframe_sm_hpos", 32'(s_hpos), 32'd0);
        chk("midframe_sm_vpos", 32'(s_vpos), 32'd0);
        chk("midframe_sm_frame_count", 32'(s_fc), 32'd0);
        chk("midframe_sm_vsync", 32'(s_vs), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset. All ports SHALL be as listed in REQ-002 to REQ-011, in the form: name, direction, width, meaning.
REQ-002 clk, input, 1: pixel clock, 25 MHz nominal; all logic on rising edge.
REQ-003 reset, input, 1: synchronous, active-high reset.
REQ-004 pix_en, input, 1: pixel-advance enable; tie high for a native 25 MHz pixel clock.
REQ-005 hpos, output, 10: current column, 0..H_TOTAL-1.
REQ-006 vpos, output, 10: current line, 0..V_TOTAL-1.
REQ-007 hsync, output, 1: horizontal sync at the SYNC_ACTIVE_HIGH polarity.
REQ-008 vsync, output, 1: vertical sync at the SYNC_ACTIVE_HIGH polarity.
REQ-009 display_on, output, 1: high while the beam is in the visible area.
REQ-010 line_start and frame_start, output, 1 each: single-cycle strobes.
REQ-011 frame_count, output, 8: number of completed frames, modulo 256.
REQ-012 The block SHALL have these parameters, in the form: name, default, meaning.
- H_DISPLAY, 640, visible columns
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- SYNC_ACTIVE_HIGH, 0, sync polarity; 0 means active-low
REQ-013 H_TOTAL and V_TOTAL SHALL be derived as the sum of the four horizontal and the four vertical parameters respectively (800 and 525 by default).

Function
REQ-014 When pix_en=1, hpos SHALL increment by 1 each cycle and wrap from H_TOTAL-1 to 0.
REQ-015 vpos SHALL increment by 1 only in the cycle in which hpos wraps, and SHALL wrap from V_TOTAL-1 to 0 when hpos also wraps.
REQ-016 When pix_en=0, every register SHALL hold its value, and line_start and frame_start SHALL be 0.
REQ-017 hsync, vsync and display_on SHALL be registered, computed from the next counter values, so they are aligned with hpos/vpos in the same cycle and glitch-free.
REQ-018 The hsync active window SHALL be hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. [656,751] by default.
REQ-019 The vsync active window SHALL be vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. [490,491] by default, for the whole line including hpos=0.
REQ-020 display_on SHALL be 1 exactly when hpos<H_DISPLAY and vpos<V_DISPLAY.
REQ-021 line_start SHALL be 1 for exactly one cycle whenever hpos=0 is presented after an advance or after reset.
REQ-022 frame_start SHALL be 1 for exactly one cycle whenever (hpos,vpos)=(0,0) is presented, and SHALL coincide with line_start.
REQ-023 frame_count SHALL increment by 1 on the (H_TOTAL-1,V_TOTAL-1)->(0,0) wrap and SHALL wrap from 255 to 0.
REQ-024 The counters SHALL never hold values >= H_TOTAL or >= V_TOTAL.
REQ-025 Counter comparisons SHALL use 10-bit unsigned arithmetic with no truncation at the default parameters.

Reset
REQ-026 When reset=1, the following cycle SHALL present: hpos=0, vpos=0, display_on=1, hsync and vsync inactive, line_start=1, frame_start=1, frame_count=0.
REQ-027 reset SHALL take priority over pix_en.
REQ-028 Reset asserted mid-line or mid-frame SHALL restart timing at (0,0) with no partial sync pulse extension.

Structure
REQ-029 The default timing constants and the derived H_TOTAL/V_TOTAL SHALL reside in the shared package vga_timing_pkg, so that downstream graphics blocks can use H_DISPLAY/V_DISPLAY.
REQ-030 A single sub-module, wrap_counter (parameterised modulus, enable, wrap flag output), SHALL be instantiated twice, once for the horizontal counter and once for the vertical counter.

Verification
REQ-031 Reset scenario: with pix_en=1, release reset -> hpos=0, vpos=0, frame_start=1 and line_start=1 in the first cycle; hpos=799 after 799 further cycles.
REQ-032 Horizontal sync scenario: run one line -> hsync low for exactly 96 cycles beginning at hpos=656; display_on high for 640 cycles per visible line.
REQ-033 Full-frame scenario: run 420000 cycles -> vsync low for exactly 1600 cycles beginning at (0,490); frame_count=1 at the next (0,0); 480 lines contain display_on.
REQ-034 Enable scenario: toggle pix_en 1,0,0,1 -> hpos advances by 2 over 4 cycles; no strobes are emitted during held cycles.
REQ-035 Mid-frame reset scenario: assert reset at (300,200) for 1 cycle -> the next cycle shows (0,0) and frame_count=0.
REQ-036 Frame-count wrap scenario: run 256 frames -> frame_count returns to 0, and line_start fires 525 times per frame.
